// File: rtl/sram_ex_adapter.sv
// Data-side front end for the SRAM controller's ex port: turns MEM-stage byte/half/word
// requests into masked, lane-replicated controller ops and returns extended read data.
module sram_ex_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        read_op_ex,
  output logic        write_op_ex,
  output logic [31:0] bus_addr_ex,
  output logic [31:0] bus_data_write_ex,
  output logic [3:0]  byte_mask_ex,
  input  logic [31:0] bus_data_read_ex,
  input  logic        bus_stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Count value seen during the last cycle allowed in ISSUE+WAIT.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = a[0];
      2'b10:   is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   lane_mask = 4'b0001 << a;
      2'b01:   lane_mask = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   lane_data = {4{wd[7:0]}};
      2'b01:   lane_data = {2{wd[15:0]}};
      2'b10:   lane_data = wd;
      default: lane_data = 32'h0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] a,
                                          input logic sgn, input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {a, 3'b000});
    h = a[1] ? rd[31:16] : rd[15:0];
    case (size)
      2'b00:   extract = sgn ? {{24{b[7]}}, b} : {24'h00_0000, b};
      2'b01:   extract = sgn ? {{16{h[15]}}, h} : {16'h0000, h};
      2'b10:   extract = rd;
      default: extract = 32'h0000_0000;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        we_q, we_d;
  logic        sgn_q, sgn_d;
  logic [3:0]  mask_q, mask_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rd_op_q, rd_op_d;
  logic        wr_op_q, wr_op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;
  logic        timeout_s;

  assign timeout_s = (cnt_q == TO_LAST);

  // Next-state and datapath decisions; timeout outranks any bus_stall event on the same edge.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    size_d   = size_q;
    we_d     = we_q;
    sgn_d    = sgn_q;
    mask_d   = mask_q;
    wdata_d  = wdata_q;
    rd_op_d  = rd_op_q;
    wr_op_d  = wr_op_q;
    cnt_d    = cnt_q;
    rvalid_d = 1'b0;
    rdata_d  = 32'h0000_0000;
    rerr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          size_d = req_size;
          we_d   = req_we;
          sgn_d  = req_signed;
          if (is_misaligned(req_size, req_addr[1:0])) begin
            state_d  = S_RESP;
            rvalid_d = 1'b1;
            rerr_d   = 1'b1;
            mask_d   = 4'b0000;
            wdata_d  = 32'h0000_0000;
          end else begin
            state_d = S_ISSUE;
            rd_op_d = ~req_we;
            wr_op_d = req_we;
            mask_d  = lane_mask(req_size, req_addr[1:0]);
            wdata_d = lane_data(req_size, req_wdata);
            cnt_d   = 8'd0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout_s) begin
          state_d  = S_RESP;
          rd_op_d  = 1'b0;
          wr_op_d  = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
        end else if (bus_stall) begin
          state_d = S_WAIT;
          rd_op_d = 1'b0;
          wr_op_d = 1'b0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (timeout_s) begin
          state_d  = S_RESP;
          rd_op_d  = 1'b0;
          wr_op_d  = 1'b0;
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
        end else if (!bus_stall) begin
          state_d  = S_RESP;
          rvalid_d = 1'b1;
          rdata_d  = we_q ? 32'h0000_0000 : extract(size_q, addr_q[1:0], sgn_q, bus_data_read_ex);
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        rd_op_d = 1'b0;
        wr_op_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any access without a response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'h0000_0000;
      size_q   <= 2'b00;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      mask_q   <= 4'b0000;
      wdata_q  <= 32'h0000_0000;
      rd_op_q  <= 1'b0;
      wr_op_q  <= 1'b0;
      cnt_q    <= 8'd0;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      we_q     <= we_d;
      sgn_q    <= sgn_d;
      mask_q   <= mask_d;
      wdata_q  <= wdata_d;
      rd_op_q  <= rd_op_d;
      wr_op_q  <= wr_op_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  assign req_ready         = (state_q == S_IDLE);
  assign busy              = (state_q != S_IDLE);
  assign read_op_ex        = rd_op_q;
  assign write_op_ex       = wr_op_q;
  assign bus_addr_ex       = addr_q;
  assign bus_data_write_ex = wdata_q;
  assign byte_mask_ex      = mask_q;
  assign resp_valid        = rvalid_q;
  assign resp_rdata        = rdata_q;
  assign resp_err          = rerr_q;

endmodule

// File: tb/tb_sram_ex_adapter.sv
// Directed plus randomized bench for sram_ex_adapter with a byte-level reference model
// and a scripted controller that drives bus_stall.
module tb_sram_ex_adapter;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        read_op_ex;
  logic        write_op_ex;
  logic [31:0] bus_addr_ex;
  logic [31:0] bus_data_write_ex;
  logic [3:0]  byte_mask_ex;
  logic [31:0] bus_data_read_ex = 32'h0;
  logic        bus_stall = 1'b0;

  int total = 0;
  int passed = 0;
  int fails = 0;

  sram_ex_adapter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .busy(busy), .read_op_ex(read_op_ex),
    .write_op_ex(write_op_ex), .bus_addr_ex(bus_addr_ex),
    .bus_data_write_ex(bus_data_write_ex), .byte_mask_ex(byte_mask_ex),
    .bus_data_read_ex(bus_data_read_ex), .bus_stall(bus_stall)
  );

  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: an access covers n = 2**size bytes starting at byte offset addr%4.
  function automatic logic m_err(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b11) return 1'b1;
    return (int'(addr[1:0]) % (1 << size)) != 0;
  endfunction

  function automatic logic [3:0] m_mask(input logic [1:0] size, input logic [31:0] addr);
    logic [3:0] m;
    int n;
    int off;
    n = 1 << size;
    off = int'(addr[1:0]);
    m = 4'h0;
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] w;
    int n;
    n = 1 << size;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] size, input logic [31:0] addr,
                                          input logic sgn, input logic [31:0] rd);
    logic [31:0] v;
    int n;
    int off;
    n = 1 << size;
    off = int'(addr[1:0]);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (((rd >> (8*(off+i))) & 32'hFF) << (8*i));
    if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // One request; the controller raises bus_stall dly cycles after issue for len cycles (len 0 = never).
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd,
                        input int dly, input int len);
    logic        normal;
    logic        op_on;
    logic [31:0] exp_rd;
    int          r;
    check1("ready_before_req", req_ready, 1'b1);
    check1("idle_not_busy", busy, 1'b0);
    req_valid = 1'b1;
    req_we = we;
    req_size = size;
    req_signed = sgn;
    req_addr = addr;
    req_wdata = wd;
    bus_data_read_ex = rd;
    bus_stall = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (m_err(size, addr)) begin
      check1("err_resp_valid", resp_valid, 1'b1);
      check1("err_resp_err", resp_err, 1'b1);
      check32("err_rdata", resp_rdata, 32'h0);
      check1("err_no_rd_op", read_op_ex, 1'b0);
      check1("err_no_wr_op", write_op_ex, 1'b0);
      check1("err_not_ready", req_ready, 1'b0);
      @(negedge clk);
      check1("err_resp_drop", resp_valid, 1'b0);
      check1("err_ready_after", req_ready, 1'b1);
    end else begin
      normal = (len > 0) && (dly + len < TO - 1);
      r = normal ? dly + len + 1 : TO;
      exp_rd = we ? 32'h0 : m_rdata(size, addr, sgn, rd);
      for (int k = 0; k < r; k++) begin
        bus_stall = (k >= dly) && (k < dly + len);
        op_on = (len == 0) || (k <= dly);
        check1("read_op", read_op_ex, op_on && !we);
        check1("write_op", write_op_ex, op_on && we);
        check1("no_early_resp", resp_valid, 1'b0);
        check1("busy_active", busy, 1'b1);
        if (k == 0) begin
          check32("byte_mask", {28'h0, byte_mask_ex}, {28'h0, m_mask(size, addr)});
          check32("wdata_lanes", bus_data_write_ex, m_wdata(size, wd));
          check32("bus_addr", bus_addr_ex, addr);
        end
        @(negedge clk);
      end
      bus_stall = 1'b0;
      check1("resp_valid", resp_valid, 1'b1);
      check1("resp_err", resp_err, !normal);
      check32("resp_rdata", resp_rdata, normal ? exp_rd : 32'h0);
      check1("resp_no_ops", read_op_ex | write_op_ex, 1'b0);
      check1("resp_not_ready", req_ready, 1'b0);
      @(negedge clk);
      check1("resp_drop", resp_valid, 1'b0);
      check1("ready_after", req_ready, 1'b1);
    end
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          ln;
    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_ready", req_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);
    check1("rst_ops", read_op_ex | write_op_ex, 1'b0);
    check1("rst_resp_valid", resp_valid, 1'b0);
    check32("rst_addr", bus_addr_ex, 32'h0);
    check32("rst_wdata", bus_data_write_ex, 32'h0);
    check32("rst_mask", {28'h0, byte_mask_ex}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Directed cases.
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1, 2);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'h80FF_0000, 1, 1);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h80FF_0000, 0, 3);
    do_req(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000_BEEF, 32'h0, 2, 2);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'hFFFF_FFFF, 0, 1);
    do_req(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 32'hFFFF_FFFF, 0, 1);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'hAAAA_5555, 0, 0);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 12, 1);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0, 32'h8001_7FFF, 13, 1);
    do_req(1'b1, 2'b00, 1'b0, 32'h0000_0021, 32'h0000_00A5, 32'h0, 14, 3);

    // Reset while the access sits in WAIT.
    req_valid = 1'b1;
    req_we = 1'b0;
    req_size = 2'b10;
    req_addr = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    bus_stall = 1'b1;
    @(negedge clk);
    check1("wait_busy", busy, 1'b1);
    #2 rst = 1'b0;
    #1;
    check1("arst_ops", read_op_ex | write_op_ex, 1'b0);
    check1("arst_busy", busy, 1'b0);
    check1("arst_resp", resp_valid, 1'b0);
    check1("arst_ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    bus_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check1("post_rst_no_resp", resp_valid, 1'b0);
      check1("post_rst_idle", busy, 1'b0);
    end

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      ln = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
             int'($urandom_range(0, 4)), ln);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
